// File: rtl/led_mmio_bridge.sv
// led_mmio_bridge: decodes CPU accesses to the LED MMIO window, buffers stores, paces LED writes, serves ordered read-back.
module led_mmio_bridge #(
  parameter logic [31:0] LED_BASE  = 32'hFFFF_FC60,
  parameter int          DEPTH     = 4,
  parameter int          ISSUE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        led_we,
  output logic [1:0]  led_addr,
  output logic [15:0] led_wdata,
  input  logic [15:0] led_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(ISSUE_GAP + 2);
  logic [17:0]   fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;
  logic [17:0]   dec, head;
  logic          hit, off_ok, full, empty, push, pop, serve, bad;
  logic          unused_hi;
  assign unused_hi = ^wdata[31:16];
  always_comb begin
    hit    = addr[31:3] == LED_BASE[31:3];
    off_ok = addr[2:0] == 3'd0 || addr[2:0] == 3'd2 || addr[2:0] == 3'd4;
    dec    = addr[2:0] == 3'd2 ? {2'b10, 8'h00, wdata[7:0]} : {addr[2] ? 2'b01 : 2'b00, wdata[15:0]};
    full   = count == CW'(DEPTH);
    empty  = count == '0;
    push   = mem_write & hit & off_ok & ~full;
    // an empty FIFO forwards the incoming store straight to the issue register
    pop    = (~empty | push) & (gap == '0);
    head   = empty ? dec : fifo[rd_ptr];
    serve  = mem_read & ~mem_write & hit & off_ok & empty & ~led_we;
    bad    = hit & (((mem_write | mem_read) & ~off_ok) | (mem_write & mem_read));
    stall  = hit & ((mem_write & full) | (mem_read & ~mem_write & off_ok & ~(empty & ~led_we)));
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= dec;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap       <= '0;
      led_we    <= 1'b0;
      led_addr  <= '0;
      led_wdata <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + CW'(push) - CW'(pop);
      gap    <= pop ? GW'(ISSUE_GAP) : (gap != '0 ? gap - GW'(1) : gap);
      led_we <= pop;
      if (pop) {led_addr, led_wdata} <= head;
      rvalid <= serve;
      if (serve) rdata <= {16'h0000, led_rdata};
      if (bad) err <= 1'b1;
    end
endmodule
